// File: rtl/dual_branch_predictor.sv
// Two-slot branch predictor: 2-bit counter BHT with a tagged direct-mapped BTB.
// Combinational predict for both fetch slots, registered two-slot training (slot 1 older).
module dual_branch_predictor #(
  parameter int PC_W  = 11,
  parameter int IDX_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] PCF1,
  input  logic [PC_W-1:0] PCF2,
  output logic            PredictionF1,
  output logic            PredictionF2,
  output logic [PC_W-1:0] PredTargetF1,
  output logic [PC_W-1:0] PredTargetF2,
  input  logic            UpdateEn1,
  input  logic            UpdateEn2,
  input  logic [PC_W-1:0] UpdatePC1,
  input  logic [PC_W-1:0] UpdatePC2,
  input  logic            branch_taken1,
  input  logic            branch_taken2,
  input  logic [PC_W-1:0] branchAdderResultM1,
  input  logic [PC_W-1:0] branchAdderResultM2
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = PC_W - IDX_W;

  typedef struct packed {
    logic             valid;
    logic [1:0]       ctr;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  tgt;
  } entry_t;

  entry_t mem_q [N];
  entry_t mem_d [N];

  function automatic entry_t train(input entry_t e, input logic en, input logic [PC_W-1:0] pc,
                                   input logic taken, input logic [PC_W-1:0] tgt);
    entry_t r;
    logic   hit;
    r   = e;
    hit = e.valid && (e.tag == pc[PC_W-1:IDX_W]);
    if (en) begin
      if (hit) begin
        if (taken) begin
          if (e.ctr != 2'b11) r.ctr = e.ctr + 2'd1;
          r.tgt = tgt;
        end else if (e.ctr != 2'b00) begin
          r.ctr = e.ctr - 2'd1;
        end
      end else if (taken) begin
        r.valid = 1'b1;
        r.ctr   = 2'b10;
        r.tag   = pc[PC_W-1:IDX_W];
        r.tgt   = tgt;
      end
    end
    return r;
  endfunction

  entry_t rd1, rd2;
  assign rd1 = mem_q[PCF1[IDX_W-1:0]];
  assign rd2 = mem_q[PCF2[IDX_W-1:0]];

  assign PredictionF1 = rd1.valid && (rd1.tag == PCF1[PC_W-1:IDX_W]) && rd1.ctr[1];
  assign PredictionF2 = rd2.valid && (rd2.tag == PCF2[PC_W-1:IDX_W]) && rd2.ctr[1];
  assign PredTargetF1 = PredictionF1 ? rd1.tgt : '0;
  assign PredTargetF2 = PredictionF2 ? rd2.tgt : '0;

  // Slot 2 trains on the slot-1 result, so a shared index chains both updates.
  always_comb begin
    mem_d = mem_q;
    mem_d[UpdatePC1[IDX_W-1:0]] = train(mem_q[UpdatePC1[IDX_W-1:0]], UpdateEn1, UpdatePC1,
                                        branch_taken1, branchAdderResultM1);
    mem_d[UpdatePC2[IDX_W-1:0]] = train(mem_d[UpdatePC2[IDX_W-1:0]], UpdateEn2, UpdatePC2,
                                        branch_taken2, branchAdderResultM2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= {1'b0, 2'b01, {TAG_W{1'b0}}, {PC_W{1'b0}}};
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_dual_branch_predictor.sv
// Randomized and directed bench for dual_branch_predictor against a per-entry behavioural model.
module tb_dual_branch_predictor;
  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] PCF1, PCF2;
  logic        PredictionF1, PredictionF2;
  logic [10:0] PredTargetF1, PredTargetF2;
  logic        UpdateEn1, UpdateEn2;
  logic [10:0] UpdatePC1, UpdatePC2;
  logic        branch_taken1, branch_taken2;
  logic [10:0] branchAdderResultM1, branchAdderResultM2;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  bit m_valid [64];
  int m_ctr   [64];
  int m_tag   [64];
  int m_tgt   [64];

  dual_branch_predictor #(.PC_W(11), .IDX_W(6)) dut (
    .clk(clk), .rst(rst),
    .PCF1(PCF1), .PCF2(PCF2),
    .PredictionF1(PredictionF1), .PredictionF2(PredictionF2),
    .PredTargetF1(PredTargetF1), .PredTargetF2(PredTargetF2),
    .UpdateEn1(UpdateEn1), .UpdateEn2(UpdateEn2),
    .UpdatePC1(UpdatePC1), .UpdatePC2(UpdatePC2),
    .branch_taken1(branch_taken1), .branch_taken2(branch_taken2),
    .branchAdderResultM1(branchAdderResultM1), .branchAdderResultM2(branchAdderResultM2)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a table of saturating counters in 0..3 plus tag/target, trained in program order.
  task automatic m_train(input logic [10:0] pc, input logic tk, input logic [10:0] tg);
    int i, t;
    i = int'(pc[5:0]);
    t = int'(pc[10:6]);
    if (m_valid[i] && m_tag[i] == t) begin
      if (tk) begin
        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = int'(tg);
      end else begin
        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (tk) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = t;
      m_tgt[i]   = int'(tg);
      m_ctr[i]   = 2;
    end
  endtask

  function automatic int exp_pred(input logic [10:0] pc);
    int i;
    i = int'(pc[5:0]);
    return (m_valid[i] && m_tag[i] == int'(pc[10:6]) && m_ctr[i] >= 2) ? 1 : 0;
  endfunction

  function automatic int exp_tgt(input logic [10:0] pc);
    return exp_pred(pc) != 0 ? m_tgt[int'(pc[5:0])] : 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 1;
      end
    end else begin
      if (UpdateEn1) m_train(UpdatePC1, branch_taken1, branchAdderResultM1);
      if (UpdateEn2) m_train(UpdatePC2, branch_taken2, branchAdderResultM2);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("cyc_pred1", int'(PredictionF1), exp_pred(PCF1));
      cmp("cyc_tgt1",  int'(PredTargetF1), exp_tgt(PCF1));
      cmp("cyc_pred2", int'(PredictionF2), exp_pred(PCF2));
      cmp("cyc_tgt2",  int'(PredTargetF2), exp_tgt(PCF2));
    end
  end

  task automatic upd(input bit e1, input logic [10:0] p1, input bit t1, input logic [10:0] g1,
                     input bit e2, input logic [10:0] p2, input bit t2, input logic [10:0] g2);
    UpdateEn1 = e1; UpdatePC1 = p1; branch_taken1 = t1; branchAdderResultM1 = g1;
    UpdateEn2 = e2; UpdatePC2 = p2; branch_taken2 = t2; branchAdderResultM2 = g2;
    @(posedge clk);
    #1;
    UpdateEn1 = 1'b0;
    UpdateEn2 = 1'b0;
  endtask

  task automatic upd1(input logic [10:0] p, input bit t);
    upd(1'b1, p, t, 11'h120, 1'b0, 11'h0, 1'b0, 11'h0);
  endtask

  task automatic upd2(input logic [10:0] p, input bit t, input logic [10:0] g);
    upd(1'b0, 11'h0, 1'b0, 11'h0, 1'b1, p, t, g);
  endtask

  function automatic logic [10:0] rand_pc();
    return {4'b0, 1'($urandom_range(0, 3)), 4'b0, 2'($urandom_range(0, 3))} | 11'($urandom_range(0, 1) << 10);
  endfunction

  initial begin
    rst = 1'b0;
    PCF1 = '0; PCF2 = '0;
    UpdateEn1 = 1'b0; UpdateEn2 = 1'b0;
    UpdatePC1 = '0; UpdatePC2 = '0;
    branch_taken1 = 1'b0; branch_taken2 = 1'b0;
    branchAdderResultM1 = '0; branchAdderResultM2 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    chk_on = 1'b1;

    // Predict and allocate in the same cycle: old state visible until the edge.
    PCF1 = 11'h045; PCF2 = 11'h085;
    UpdateEn1 = 1'b1; UpdatePC1 = 11'h045; branch_taken1 = 1'b1; branchAdderResultM1 = 11'h120;
    #2;
    cmp("same_cycle_pred1", int'(PredictionF1), 0);
    @(posedge clk);
    #1;
    UpdateEn1 = 1'b0;
    cmp("alloc_pred1", int'(PredictionF1), 1);
    cmp("alloc_tgt1", int'(PredTargetF1), 'h120);
    cmp("other_tag_pred2", int'(PredictionF2), 0);

    // Saturation and hysteresis.
    repeat (4) upd1(11'h045, 1'b1);
    upd1(11'h045, 1'b0);
    cmp("hyst_1nt", int'(PredictionF1), 1);
    upd1(11'h045, 1'b0);
    cmp("hyst_2nt", int'(PredictionF1), 0);
    repeat (4) upd1(11'h045, 1'b0);
    upd1(11'h045, 1'b1);
    cmp("sat0_1t", int'(PredictionF1), 0);
    upd1(11'h045, 1'b1);
    cmp("sat0_2t", int'(PredictionF1), 1);

    // Dual same-index update from ctr=01 reaches 11.
    upd1(11'h045, 1'b0);
    cmp("ctr01_pred", int'(PredictionF1), 0);
    upd(1'b1, 11'h045, 1'b1, 11'h120, 1'b1, 11'h045, 1'b1, 11'h120);
    cmp("dual_pred", int'(PredictionF1), 1);
    upd1(11'h045, 1'b0);
    cmp("dual_1nt", int'(PredictionF1), 1);
    upd1(11'h045, 1'b0);
    cmp("dual_2nt", int'(PredictionF1), 0);

    // Not-taken miss does not allocate; taken does.
    PCF2 = 11'h300;
    upd2(11'h300, 1'b0, 11'h055);
    cmp("nt_miss_pred2", int'(PredictionF2), 0);
    upd2(11'h300, 1'b1, 11'h010);
    cmp("miss_alloc_pred2", int'(PredictionF2), 1);
    cmp("miss_alloc_tgt2", int'(PredTargetF2), 'h010);

    // Slot 2 allocation with another tag evicts slot 1's result.
    PCF2 = 11'h085;
    upd(1'b1, 11'h045, 1'b1, 11'h120, 1'b1, 11'h085, 1'b1, 11'h0AA);
    cmp("evict_pred1", int'(PredictionF1), 0);
    cmp("evict_pred2", int'(PredictionF2), 1);
    cmp("evict_tgt2", int'(PredTargetF2), 'h0AA);

    // ctr=11, slot1 not-taken then slot2 taken stays at 11.
    upd2(11'h085, 1'b1, 11'h0AA);
    upd(1'b1, 11'h085, 1'b0, 11'h0, 1'b1, 11'h085, 1'b1, 11'h0AB);
    cmp("chain_tgt2", int'(PredTargetF2), 'h0AB);
    upd2(11'h085, 1'b0, 11'h0);
    cmp("chain_1nt", int'(PredictionF2), 1);
    upd2(11'h085, 1'b0, 11'h0);
    cmp("chain_2nt", int'(PredictionF2), 0);

    // Asynchronous reset mid-cycle with an update pending.
    upd1(11'h045, 1'b1);
    cmp("pre_reset_pred1", int'(PredictionF1), 1);
    UpdateEn1 = 1'b1; UpdatePC1 = 11'h045; branch_taken1 = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    cmp("reset_pred1", int'(PredictionF1), 0);
    cmp("reset_tgt1", int'(PredTargetF1), 0);
    @(posedge clk);
    #1;
    UpdateEn1 = 1'b0;
    rst = 1'b1;
    cmp("post_reset_pred1", int'(PredictionF1), 0);
    cmp("post_reset_tgt1", int'(PredTargetF1), 0);

    // Random traffic on a small PC pool to force index and tag collisions.
    for (int n = 0; n < 3000; n++) begin
      PCF1 = rand_pc();
      PCF2 = ($urandom_range(0, 3) == 0) ? PCF1 : rand_pc();
      UpdateEn1 = 1'($urandom_range(0, 1));
      UpdateEn2 = 1'($urandom_range(0, 1));
      UpdatePC1 = rand_pc();
      UpdatePC2 = ($urandom_range(0, 2) == 0) ? UpdatePC1 : rand_pc();
      branch_taken1 = ($urandom_range(0, 9) < 6);
      branch_taken2 = ($urandom_range(0, 9) < 6);
      branchAdderResultM1 = 11'($urandom);
      branchAdderResultM2 = 11'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    UpdateEn1 = 1'b0;
    UpdateEn2 = 1'b0;
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dual_branch_predictor.md
# dual_branch_predictor

Two-slot dynamic branch predictor for the superscalar fetch stage: 2-bit saturating-counter BHT plus a tagged direct-mapped BTB. Each cycle it predicts direction and target for both fetch slots (PCF1, PCF2). It is trained by the two resolved branches in the M stage. Its per-slot prediction bit travels down the pipe and becomes PredictionM1/PredictionM2 for the downstream PC-correction logic, which compares it against the resolved outcome.

## Interface

**Parameters**
- `PC_W`, 11: PC and target width.
- `IDX_W`, 6: index bits, giving 2^IDX_W entries. Tag is `PC[PC_W-1:IDX_W]`.

**Ports**
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `PCF1`, `PCF2`  in  PC_W  fetch-slot PCs.
- `PredictionF1`, `PredictionF2`  out  1  predict taken.
- `PredTargetF1`, `PredTargetF2`  out  PC_W  predicted target; valid only when the matching prediction is 1, otherwise 0.
- `UpdateEn1`, `UpdateEn2`  in  1  M-stage slot holds a resolved conditional branch.
- `UpdatePC1`, `UpdatePC2`  in  PC_W  PC of the resolved branch.
- `branch_taken1`, `branch_taken2`  in  1  resolved direction.
- `branchAdderResultM1`, `branchAdderResultM2`  in  PC_W  resolved target.

## Operation

**State**
- Per entry: 2-bit counter `ctr`, `valid`, tag (PC_W-IDX_W bits), target (PC_W bits).

**Predict** (combinational read, same cycle)
- `hit = valid[idx] & (tag[idx] == PC tag)`.
- `PredictionFx = hit & ctr[idx][1]`.
- `PredTargetFx = PredictionFx ? target[idx] : 0`.
- Both slots read independently. Equal indices or equal PCs are legal.

**Update** (registered)
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Taken → increment, saturating at 11. Not-taken → decrement, saturating at 00.
- Tag mismatch or invalid entry:
  - Taken: allocate the entry. Set valid=1, tag=UpdatePC tag, target=resolved target, ctr=10.
  - Not-taken: no change at all; no allocation.
- Tag hit:
  - Taken: update ctr and overwrite target.
  - Not-taken: update ctr only; target and tag unchanged.

**Simultaneous updates to the same index**
- Slot 1 is older: apply slot 1, then apply slot 2 to the slot-1 result, in the same cycle.
- Example: ctr=01, both taken, same tag → 11.
- Example: ctr=11, slot1 not-taken, slot2 taken → 11 (10, then saturating back to 11).
- Slot 2 allocation with a different tag evicts the slot-1 result; the final tag, target and valid come from slot 2.

**Other rules**
- Updates to different indices are fully independent.
- With `UpdateEnx`=0, that slot's inputs are ignored.

## Timing

**Reset**
- Asynchronous assert, at any time including mid-update, clears all `valid` bits and sets every `ctr` to 01.
- Tags and targets are don't-care after reset.
- Outputs during and after reset: `PredictionF1`/`PredictionF2` = 0, `PredTargetF1`/`PredTargetF2` = 0.
- Release is synchronous to `clk` at the system level.

**Latency and forwarding**
- Prediction latency: 0 cycles, combinational from `PCF`.
- Update latency: 1 cycle. An update sampled at edge N is visible to predictions from edge N onward, i.e. in cycle N+1.
- No same-cycle write→read forwarding. A predict and update to the same index in the same cycle returns the pre-update state.

**Handshake and timing paths**
- No handshake or stall. Updates are accepted every cycle `UpdateEnx` is high.
- Stalls are handled upstream by holding `PCF`.
- Critical path: array read plus tag compare for predict; chained two-slot counter update for write.

## Test plan

All cases use IDX_W=6 (index = PC[5:0], tag = PC[10:6]).

1. **Reset state:** assert `rst`=0 mid-run after training, release, drive PCF1=0x045 → PredictionF1=0, PredTargetF1=0.
2. **Allocate and hit:** UpdateEn1=1, UpdatePC1=0x045, taken, target 0x120. Next cycle PCF1=0x045 → PredictionF1=1, PredTargetF1=0x120. PCF2=0x085 (same index, tag 2) → PredictionF2=0.
3. **Saturation and hysteresis:** from ctr=10, four taken updates, then one not-taken → still predicts taken (ctr=10). A second not-taken → PredictionF1=0. Four more not-taken → ctr=00; two taken are needed to predict taken again.
4. **Dual same-index update:** entry ctr=01, both slots update 0x045 taken in one cycle → ctr=11 (checked by two not-taken updates still predicting taken after the first).
5. **Not-taken miss does not allocate:** UpdatePC2=0x300, not-taken → PCF2=0x300 → PredictionF2=0 and valid unchanged. Then taken with target 0x010 → predicts 0x010.
6. **Same-cycle read/update:** PCF1=0x045 while updating 0x045 allocate-taken → PredictionF1=0 that cycle, 1 the next.
